multicycle_control_fsm: RTL and testbench

//   Multicycle sequencer for the CPU datapath (PC, instruction register, register file, ALU,

---
 rtl/multicycle_control_fsm.sv | 139 +++++++++++++
 tb/tb_multicycle_control_fsm.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: steps each instruction through fetch/decode/execute/memory/writeback,
// issuing datapath enables and mux selects, with memory-timeout and illegal-instruction traps.
module multicycle_control_fsm #(
   parameter int MEM_TIMEOUT = 15,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   Run,
   input  logic [5:0]             Opcode,
   input  logic [5:0]             Funct,
   input  logic                   Zero,
   input  logic                   MemReady,
   output logic                   IFetch,
   output logic                   IRWrite,
   output logic                   PCWrite,
   output logic [1:0]             PCSrc,
   output logic                   RegDst,
   output logic                   ALUSrc,
   output logic [1:0]             ALUControl,
   output logic                   MemRead,
   output logic                   MemWrite,
   output logic                   MemToReg,
   output logic                   RegWrite,
   output logic [2:0]             State,
   output logic                   Halted,
   output logic                   Trap,
   output logic [1:0]             TrapCause,
   output logic [COUNT_WIDTH-1:0] RetiredCount
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALTED, TRAP} state_t;
   state_t state, next;
   logic [WW-1:0] wait_cnt, wait_nxt;
   logic [1:0] cause_nxt, alu_op;
   logic retire, waiting, timeout;
   logic is_r, is_lw, is_sw, is_addi, is_beq, is_bne, is_j, is_halt, illegal;
   assign is_r    = Opcode == 6'h00 && (Funct == 6'h20 || Funct == 6'h22 || Funct == 6'h24 || Funct == 6'h25);
   assign is_lw   = Opcode == 6'h23;
   assign is_sw   = Opcode == 6'h2B;
   assign is_addi = Opcode == 6'h08;
   assign is_beq  = Opcode == 6'h04;
   assign is_bne  = Opcode == 6'h05;
   assign is_j    = Opcode == 6'h02;
   assign is_halt = Opcode == 6'h3F;
   assign illegal = !(is_r || is_lw || is_sw || is_addi || is_beq || is_bne || is_j || is_halt);
   assign alu_op  = is_r ? (Funct == 6'h20 ? 2'b00 : Funct == 6'h22 ? 2'b01 : Funct == 6'h24 ? 2'b10 : 2'b11)
                         : (is_beq || is_bne) ? 2'b01 : 2'b00;
   // counter idles at zero outside memory waits, so entering FETCH/MEMORY always starts from zero
   assign waiting  = (state == FETCH || state == MEMORY) && !MemReady;
   assign timeout  = waiting && wait_cnt == WW'(MEM_TIMEOUT - 1);
   assign wait_nxt = waiting ? wait_cnt + WW'(1) : '0;
   assign State    = state;
   assign Halted   = state == HALTED;
   assign Trap     = state == TRAP;
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         RetiredCount <= '0;
         TrapCause    <= 2'b00;
      end else begin
         state        <= next;
         wait_cnt     <= wait_nxt;
         RetiredCount <= RetiredCount + COUNT_WIDTH'(retire);
         TrapCause    <= cause_nxt;
      end
   end
   always_comb begin
      next       = state;
      cause_nxt  = TrapCause;
      retire     = 1'b0;
      IFetch     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 2'b00;
      RegDst     = 1'b0;
      ALUSrc     = 1'b0;
      ALUControl = 2'b00;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemToReg   = 1'b0;
      RegWrite   = 1'b0;
      case (state)
         IDLE: next = Run ? FETCH : IDLE;
         FETCH: begin
            IFetch  = 1'b1;
            IRWrite = MemReady;
            if (MemReady) next = DECODE;
         end
         DECODE: begin
            if (illegal) begin
               next      = TRAP;
               cause_nxt = 2'b01;
            end else if (is_halt) next = HALTED;
            else if (is_j) begin
               PCWrite = 1'b1;
               PCSrc   = 2'b10;
               retire  = 1'b1;
            end else next = EXECUTE;
         end
         EXECUTE: begin
            ALUSrc     = is_lw || is_sw || is_addi;
            ALUControl = alu_op;
            if (is_beq || is_bne) begin
               PCWrite = 1'b1;
               PCSrc   = {1'b0, (is_beq && Zero) || (is_bne && !Zero)};
               retire  = 1'b1;
            end else next = (is_lw || is_sw) ? MEMORY : WRITEBACK;
         end
         MEMORY: begin
            ALUSrc     = 1'b1;
            ALUControl = alu_op;
            MemRead    = is_lw;
            MemWrite   = is_sw;
            if (MemReady) begin
               if (is_lw) next = WRITEBACK;
               else begin
                  PCWrite = 1'b1;
                  retire  = 1'b1;
               end
            end
         end
         WRITEBACK: begin
            RegWrite = 1'b1;
            PCWrite  = 1'b1;
            RegDst   = is_r;
            MemToReg = is_lw;
            retire   = 1'b1;
         end
         default: ;
      endcase
      if (timeout) begin
         next      = TRAP;
         cause_nxt = 2'b10;
      end
      if (retire) next = Run ? FETCH : IDLE;
   end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: instruction-level trace model feeds a per-cycle expectation queue;
// a negedge monitor pops and compares DUT outputs against it.
module tb_multicycle_control_fsm;
   logic Clk = 0, Rst = 1, Run = 0, Zero = 0, MemReady = 0;
   logic [5:0] Opcode = 0, Funct = 0;
   logic IFetch, IRWrite, PCWrite, RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, Halted, Trap;
   logic [1:0] PCSrc, ALUControl, TrapCause;
   logic [2:0] State;
   logic [31:0] RetiredCount;
   logic [14:0] act_ctl;
   typedef struct packed {logic [2:0] st; logic [14:0] ctl; logic [1:0] cause; logic [31:0] ret;} rec_t;
   localparam logic [2:0] S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3, S_MEM = 4, S_WB = 5, S_HALT = 6, S_TRAP = 7;
   rec_t q[$];
   int total = 0, bad = 0;
   logic [31:0] m_ret = 0;
   logic [1:0] m_cause = 0;
   bit at_idle = 1;
   logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h11};
   logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

   always #5 Clk = ~Clk;

   multicycle_control_fsm #(.MEM_TIMEOUT(15), .COUNT_WIDTH(32)) dut (
      .Clk(Clk), .Rst(Rst), .Run(Run), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
      .IFetch(IFetch), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegDst(RegDst), .ALUSrc(ALUSrc),
      .ALUControl(ALUControl), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite),
      .State(State), .Halted(Halted), .Trap(Trap), .TrapCause(TrapCause), .RetiredCount(RetiredCount));

   assign act_ctl = {IFetch, IRWrite, PCWrite, PCSrc, RegDst, ALUSrc, ALUControl, MemRead, MemWrite, MemToReg, RegWrite, Halted, Trap};

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s at %0t: actual=%h required=%h", n, $time, a, e);
      end
   endtask

   always @(negedge Clk) begin : monitor
      rec_t r;
      if (q.size() > 0) begin
         r = q.pop_front();
         chk("state", 32'(State), 32'(r.st));
         chk("controls", 32'(act_ctl), 32'(r.ctl));
         chk("trap_cause", 32'(TrapCause), 32'(r.cause));
         chk("retired", RetiredCount, r.ret);
      end
   end

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [14:0] cw(input logic ifc, irw, pcw, input logic [1:0] pcs, input logic rd, as,
                                      input logic [1:0] ac, input logic mr, mw, m2r, rw, h, t);
      return {ifc, irw, pcw, pcs, rd, as, ac, mr, mw, m2r, rw, h, t};
   endfunction

   // one clock cycle: drive inputs, queue what must be visible this cycle, then apply model updates
   task automatic step(input logic run, mr, z, input logic [2:0] st, input logic [14:0] ctl,
                       input logic ret_inc, input logic [1:0] nc);
      Run = run;
      MemReady = mr;
      Zero = z;
      q.push_back('{st, ctl, m_cause, m_ret});
      @(posedge Clk);
      #1;
      m_ret += 32'(ret_inc);
      m_cause = nc;
   endtask

   task automatic do_reset();
      Rst = 1;
      m_ret = 0;
      m_cause = 0;
      at_idle = 1;
      step(rb(), rb(), rb(), S_IDLE, 15'd0, 0, 2'b00);
      Rst = 0;
   endtask

   task automatic absorb(input logic [2:0] st);
      repeat (3) step(rb(), rb(), rb(), st, cw(0,0,0,0,0,0,0,0,0,0,0, st == S_HALT, st == S_TRAP), 0, m_cause);
      do_reset();
   endtask

   task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic z,
                            input logic run_after, input logic rst_mem);
      logic [5:0] op, fn;
      logic r, lw, sw, ad, bq, bn, jj, hl, ill, as, tk;
      logic [1:0] ac;
      logic [14:0] mem;
      op = ins[31:26];
      fn = ins[5:0];
      Opcode = op;
      Funct = fn;
      r  = op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25);
      lw = op == 6'h23; sw = op == 6'h2B; ad = op == 6'h08; bq = op == 6'h04;
      bn = op == 6'h05; jj = op == 6'h02; hl = op == 6'h3F;
      ill = !(r | lw | sw | ad | bq | bn | jj | hl);
      as = lw | sw | ad;
      ac = r ? (fn == 6'h20 ? 2'd0 : fn == 6'h22 ? 2'd1 : fn == 6'h24 ? 2'd2 : 2'd3) : (bq | bn) ? 2'd1 : 2'd0;
      tk = (bq & z) | (bn & ~z);
      mem = cw(0,0,0,0,0,1,ac,lw,sw,0,0,0,0);
      if (at_idle) begin
         repeat ($urandom_range(0, 2)) step(0, rb(), rb(), S_IDLE, 15'd0, 0, m_cause);
         step(1, rb(), rb(), S_IDLE, 15'd0, 0, m_cause);
      end
      for (int i = 0; i < wf; i++) begin
         if (i == 14) begin
            step(rb(), 0, rb(), S_FETCH, cw(1,0,0,0,0,0,0,0,0,0,0,0,0), 0, 2'b10);
            absorb(S_TRAP);
            return;
         end
         step(rb(), 0, rb(), S_FETCH, cw(1,0,0,0,0,0,0,0,0,0,0,0,0), 0, m_cause);
      end
      step(rb(), 1, rb(), S_FETCH, cw(1,1,0,0,0,0,0,0,0,0,0,0,0), 0, m_cause);
      if (ill) begin
         step(rb(), rb(), rb(), S_DECODE, 15'd0, 0, 2'b01);
         absorb(S_TRAP);
         return;
      end
      if (hl) begin
         step(rb(), rb(), rb(), S_DECODE, 15'd0, 0, m_cause);
         absorb(S_HALT);
         return;
      end
      if (jj) begin
         step(run_after, rb(), rb(), S_DECODE, cw(0,0,1,2'b10,0,0,0,0,0,0,0,0,0), 1, m_cause);
         at_idle = !run_after;
         return;
      end
      step(rb(), rb(), rb(), S_DECODE, 15'd0, 0, m_cause);
      if (bq | bn) begin
         step(run_after, rb(), z, S_EXEC, cw(0,0,1,{1'b0, tk},0,as,ac,0,0,0,0,0,0), 1, m_cause);
         at_idle = !run_after;
         return;
      end
      step(rb(), rb(), rb(), S_EXEC, cw(0,0,0,0,0,as,ac,0,0,0,0,0,0), 0, m_cause);
      if (lw | sw) begin
         if (rst_mem) begin
            Run = rb();
            MemReady = 0;
            #1;
            chk("memreq_before_rst", 32'({MemRead, MemWrite}), 32'({lw, sw}));
            Rst = 1;
            #1;
            chk("memreq_after_rst", 32'({MemRead, MemWrite}), 0);
            chk("state_after_rst", 32'(State), 32'(S_IDLE));
            m_ret = 0;
            m_cause = 0;
            at_idle = 1;
            q.push_back('{S_IDLE, 15'd0, 2'b00, 32'd0});
            @(posedge Clk);
            #1;
            Rst = 0;
            return;
         end
         for (int i = 0; i < wm; i++) begin
            if (i == 14) begin
               step(rb(), 0, rb(), S_MEM, mem, 0, 2'b10);
               absorb(S_TRAP);
               return;
            end
            step(rb(), 0, rb(), S_MEM, mem, 0, m_cause);
         end
         if (sw) begin
            step(run_after, 1, rb(), S_MEM, mem | cw(0,0,1,0,0,0,0,0,0,0,0,0,0), 1, m_cause);
            at_idle = !run_after;
            return;
         end
         step(rb(), 1, rb(), S_MEM, mem, 0, m_cause);
      end
      step(run_after, rb(), rb(), S_WB, cw(0,0,1,0,r,0,0,0,0,lw,1,0,0), 1, m_cause);
      at_idle = !run_after;
   endtask

   function automatic int pick_wait();
      int s;
      s = $urandom_range(0, 19);
      return s == 0 ? 15 : s == 1 ? 14 : $urandom_range(0, 3);
   endfunction

   initial begin
      logic [5:0] op, fn;
      @(posedge Clk);
      #1;
      do_reset();
      run_instr(32'h012A4020, 0, 0, 0, 1, 0);
      run_instr(32'h8D280004, 0, 3, 0, 1, 0);
      run_instr(32'h10000003, 0, 0, 1, 1, 0);
      run_instr(32'h14000003, 0, 0, 1, 1, 0);
      run_instr(32'h14000003, 1, 0, 0, 1, 0);
      run_instr(32'h08000010, 0, 0, 0, 1, 0);
      run_instr(32'h21080001, 2, 0, 0, 1, 0);
      run_instr(32'hAD280004, 0, 2, 0, 0, 0);
      run_instr(32'h012A4022, 14, 0, 0, 1, 0);
      run_instr(32'h012A4024, 15, 0, 0, 1, 0);
      run_instr(32'hFC000000, 0, 0, 0, 1, 0);
      run_instr(32'h44000000, 0, 0, 0, 1, 0);
      run_instr(32'h0000003F, 0, 0, 0, 1, 0);
      run_instr(32'hAD280004, 0, 0, 0, 1, 1);
      run_instr(32'h8D280004, 0, 14, 0, 1, 0);
      run_instr(32'h8D280004, 0, 15, 0, 1, 0);
      repeat (200) begin
         op = ops[$urandom_range(0, 9)];
         if ($urandom_range(0, 9) == 0) op = 6'($urandom);
         fn = fns[$urandom_range(0, 4)];
         run_instr({op, 20'($urandom), fn}, pick_wait(), pick_wait(), rb(),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
      end
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge Clk);
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
